filterbank_scheduler: RTL and testbench

Sequencer that time-multiplexes one shared biquad engine across all vocoder channels and filter stages. On each accepted audio sample it issues, per channel, a modulator-bandpass, envelope-lowpass and carrier-bandpass request to the engine, collects results into working registers, and commits complete envelope/carrier channel arrays with a one-cycle valid pulse. It sits between the mic/synth sources and the mixer, replacing per-channel filter instances.

---
 rtl/filterbank_scheduler_pkg.sv | 32 +++
 rtl/filterbank_scheduler_sample_skid.sv | 34 +++
 rtl/filterbank_scheduler.sv | 228 ++++++++++++++++++++++
 tb/tb_filterbank_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/filterbank_scheduler_pkg.sv
// Shared types and constants for the vocoder filter-bank scheduler.
// Optional skid buffer is enabled with the FB_SCHED_SKID_EN macro.
package filterbank_scheduler_pkg;

  localparam int N_FILTERS = 8;

  typedef enum logic [1:0] {
    STG_MOD = 2'd0,
    STG_ENV = 2'd1,
    STG_CAR = 2'd2
  } fb_stage_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } fb_sched_state_t;

  // Magnitude of a signed 32-bit value; the most negative value maps to the most positive one.
  function automatic logic [31:0] abs_sat32(input logic signed [31:0] v);
    logic [31:0] r;
    if (v == 32'sh8000_0000) begin
      r = 32'h7FFF_FFFF;
    end else if (v < 32'sd0) begin
      r = 32'(-v);
    end else begin
      r = 32'(v);
    end
    return r;
  endfunction

endpackage

// File: rtl/filterbank_scheduler_sample_skid.sv
// One-entry holding register for a sample pair that arrives while the scheduler is busy.
// Only instantiated when FB_SCHED_SKID_EN is defined.
module sample_skid #(
  parameter int W = 40
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic [W-1:0] data
);

  logic         full_r;
  logic [W-1:0] data_r;

  // Entry register: a push wins over a simultaneous pop so the slot is refilled.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      full_r <= 1'b0;
      data_r <= '0;
    end else if (push) begin
      full_r <= 1'b1;
      data_r <= push_data;
    end else if (pop) begin
      full_r <= 1'b0;
    end
  end

  assign full = full_r;
  assign data = data_r;

endmodule

// File: rtl/filterbank_scheduler.sv
// Time-multiplexes one biquad engine over all channels: MOD, ENV, CAR per channel, then commits.
// Define FB_SCHED_SKID_EN to buffer one sample that arrives while busy.
module filterbank_scheduler
  import filterbank_scheduler_pkg::*;
#(
  parameter int N_CH  = N_FILTERS,
  parameter int MOD_W = 24,
  parameter int CAR_W = 16,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 valid_in,
  input  logic [MOD_W-1:0]     modulator_in,
  input  logic [CAR_W-1:0]     carrier_in,
  output logic                 eng_req_out,
  input  logic                 eng_ready_in,
  output logic [CH_W-1:0]      eng_ch_out,
  output logic [1:0]           eng_stage_out,
  output logic [31:0]          eng_x_out,
  input  logic                 eng_valid_in,
  input  logic [31:0]          eng_y_in,
  output logic [32*N_CH-1:0]   envelope_out,
  output logic [32*N_CH-1:0]   carrier_out,
  output logic                 valid_out,
  output logic                 busy_out,
  output logic                 overrun_out
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  fb_sched_state_t state_r, state_n;
  fb_stage_t       stage_r, stage_n;
  logic [CH_W-1:0] ch_r, ch_n;
  logic [31:0]     x_r, x_n;
  logic [31:0]     mod_r, car_r;
  logic [31:0]     env_work_r [N_CH];
  logic [31:0]     car_work_r [N_CH];
  logic [32*N_CH-1:0] envelope_r, carrier_r;
  logic            req_r, busy_r, valid_r, overrun_r;

  logic             start_s, store_s, commit_s;
  logic             pend_valid_s, overrun_set_s;
  logic [MOD_W-1:0] pend_mod_s;
  logic [CAR_W-1:0] pend_car_s;
  logic [31:0]      mod_ext_s, car_ext_s;

`ifdef FB_SCHED_SKID_EN
  logic                   skid_full_s, skid_push_s, skid_pop_s;
  logic [MOD_W+CAR_W-1:0] skid_data_s;

  sample_skid #(.W(MOD_W + CAR_W)) u_skid (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (skid_push_s),
    .push_data ({modulator_in, carrier_in}),
    .pop       (skid_pop_s),
    .full      (skid_full_s),
    .data      (skid_data_s)
  );

  // Sample source selection: a buffered sample starts before a fresh one, which then takes the slot.
  always_comb begin
    pend_valid_s = valid_in || skid_full_s;
    if (skid_full_s) begin
      {pend_mod_s, pend_car_s} = skid_data_s;
    end else begin
      {pend_mod_s, pend_car_s} = {modulator_in, carrier_in};
    end
    skid_pop_s    = (state_r == IDLE) && skid_full_s;
    skid_push_s   = valid_in && ((state_r != IDLE) ? !skid_full_s : skid_full_s);
    overrun_set_s = valid_in && (state_r != IDLE) && skid_full_s;
  end
`else
  // Sample source selection: anything arriving while busy is lost.
  always_comb begin
    pend_valid_s  = valid_in;
    pend_mod_s    = modulator_in;
    pend_car_s    = carrier_in;
    overrun_set_s = valid_in && (state_r != IDLE);
  end
`endif

  assign mod_ext_s = {{(32-MOD_W){pend_mod_s[MOD_W-1]}}, pend_mod_s};
  assign car_ext_s = {{(32-CAR_W){pend_car_s[CAR_W-1]}}, pend_car_s};

  // Next-state, next request fields and datapath strobes.
  always_comb begin
    state_n  = state_r;
    stage_n  = stage_r;
    ch_n     = ch_r;
    x_n      = x_r;
    start_s  = 1'b0;
    store_s  = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pend_valid_s) begin
          start_s = 1'b1;
          state_n = ISSUE;
          ch_n    = {CH_W{1'b0}};
          stage_n = STG_MOD;
          x_n     = mod_ext_s;
        end else begin
          state_n = IDLE;
        end
      end
      ISSUE: begin
        if (eng_ready_in) begin
          state_n = WAIT;
        end else begin
          state_n = ISSUE;
        end
      end
      WAIT: begin
        if (eng_valid_in) begin
          store_s = 1'b1;
          case (stage_r)
            STG_MOD: begin
              stage_n = STG_ENV;
              x_n     = abs_sat32(eng_y_in);
              state_n = ISSUE;
            end
            STG_ENV: begin
              stage_n = STG_CAR;
              x_n     = car_r;
              state_n = ISSUE;
            end
            STG_CAR: begin
              stage_n = STG_MOD;
              if (ch_r == LAST_CH) begin
                commit_s = 1'b1;
                ch_n     = {CH_W{1'b0}};
                x_n      = 32'd0;
                state_n  = IDLE;
              end else begin
                ch_n    = ch_r + CH_W'(1);
                x_n     = mod_r;
                state_n = ISSUE;
              end
            end
            default: begin
              state_n = IDLE;
            end
          endcase
        end else begin
          state_n = WAIT;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Control registers; the request fields only move on acceptance or a result.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r   <= IDLE;
      stage_r   <= STG_MOD;
      ch_r      <= {CH_W{1'b0}};
      x_r       <= 32'd0;
      req_r     <= 1'b0;
      busy_r    <= 1'b0;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r <= state_n;
      stage_r <= stage_n;
      ch_r    <= ch_n;
      x_r     <= x_n;
      req_r   <= (state_n == ISSUE);
      busy_r  <= (state_n != IDLE);
      valid_r <= commit_s;
      if (overrun_set_s) begin
        overrun_r <= 1'b1;
      end
    end
  end

  // Latched inputs, per-channel working results and committed arrays.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mod_r      <= 32'd0;
      car_r      <= 32'd0;
      envelope_r <= '0;
      carrier_r  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        env_work_r[i] <= 32'd0;
        car_work_r[i] <= 32'd0;
      end
    end else begin
      if (start_s) begin
        mod_r <= mod_ext_s;
        car_r <= car_ext_s;
      end
      if (store_s) begin
        case (stage_r)
          STG_ENV: env_work_r[ch_r] <= eng_y_in;
          STG_CAR: car_work_r[ch_r] <= eng_y_in;
          default: ;
        endcase
      end
      // The last carrier result is still on eng_y_in while the arrays are committed.
      if (commit_s) begin
        for (int i = 0; i < N_CH; i++) begin
          envelope_r[32*i +: 32] <= env_work_r[i];
          if (i == N_CH - 1) begin
            carrier_r[32*i +: 32] <= eng_y_in;
          end else begin
            carrier_r[32*i +: 32] <= car_work_r[i];
          end
        end
      end
    end
  end

  assign eng_req_out   = req_r;
  assign eng_ch_out    = ch_r;
  assign eng_stage_out = stage_r;
  assign eng_x_out     = x_r;
  assign envelope_out  = envelope_r;
  assign carrier_out   = carrier_r;
  assign valid_out     = valid_r;
  assign busy_out      = busy_r;
  assign overrun_out   = overrun_r;

endmodule

// File: tb/tb_filterbank_scheduler.sv
// Directed bench for filterbank_scheduler with a behavioural engine y = x + ch*256 + stage.
// Expectations follow the FB_SCHED_SKID_EN setting of the build.
module tb_filterbank_scheduler;

  localparam int N_CH = 8;
`ifdef FB_SCHED_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b0;
  logic              valid_in = 1'b0;
  logic [23:0]       modulator_in = 24'd0;
  logic [15:0]       carrier_in = 16'd0;
  logic              eng_req_out;
  logic              eng_ready_in = 1'b0;
  logic [2:0]        eng_ch_out;
  logic [1:0]        eng_stage_out;
  logic [31:0]       eng_x_out;
  logic              eng_valid_in = 1'b0;
  logic [31:0]       eng_y_in = 32'd0;
  logic [32*N_CH-1:0] envelope_out, carrier_out;
  logic              valid_out, busy_out, overrun_out;

  filterbank_scheduler #(.N_CH(N_CH), .MOD_W(24), .CAR_W(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in),
    .modulator_in(modulator_in), .carrier_in(carrier_in),
    .eng_req_out(eng_req_out), .eng_ready_in(eng_ready_in),
    .eng_ch_out(eng_ch_out), .eng_stage_out(eng_stage_out), .eng_x_out(eng_x_out),
    .eng_valid_in(eng_valid_in), .eng_y_in(eng_y_in),
    .envelope_out(envelope_out), .carrier_out(carrier_out),
    .valid_out(valid_out), .busy_out(busy_out), .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_mis = 0;

  // Engine controls (written by the stimulus) and engine observations (written by the model).
  bit  ready_rand = 1'b0, delay_rand = 1'b0, force_min = 1'b0;
  int  stray_cnt = 0, stray_seen = 0;
  int  stall_viol = 0, vo_count = 0;
  logic [31:0] env_x0 = 32'd0;

  bit          e_pend = 1'b0;
  int          e_cnt = 0;
  logic [31:0] e_y = 32'd0;
  logic        prev_req = 1'b0, prev_ready = 1'b0;
  logic [2:0]  prev_ch = 3'd0;
  logic [1:0]  prev_stage = 2'd0;
  logic [31:0] prev_x = 32'd0;

  // Engine model, driven on the falling edge so the DUT samples settled values.
  always @(negedge clk_in) begin
    eng_valid_in = 1'b0;
    if (stray_cnt != stray_seen) begin
      stray_seen   = stray_cnt;
      eng_valid_in = 1'b1;
      eng_y_in     = 32'h0BAD_F00D;
    end else if (e_pend) begin
      if (e_cnt <= 1) begin
        eng_valid_in = 1'b1;
        eng_y_in     = e_y;
        e_pend       = 1'b0;
      end else begin
        e_cnt--;
      end
    end
    if (eng_req_out && prev_req && !prev_ready) begin
      if (eng_ch_out !== prev_ch || eng_stage_out !== prev_stage || eng_x_out !== prev_x)
        stall_viol++;
    end
    eng_ready_in = (ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1) && !e_pend;
    if (eng_req_out && eng_ready_in) begin
      e_pend = 1'b1;
      e_cnt  = delay_rand ? int'($urandom_range(1, 5)) : 1;
      if (force_min && eng_ch_out == 3'd0 && eng_stage_out == 2'd0)
        e_y = 32'h8000_0000;
      else
        e_y = eng_x_out + 32'(eng_ch_out) * 32'd256 + 32'(eng_stage_out);
      if (eng_ch_out == 3'd0 && eng_stage_out == 2'd1)
        env_x0 = eng_x_out;
    end
    prev_req   = eng_req_out;
    prev_ready = eng_ready_in;
    prev_ch    = eng_ch_out;
    prev_stage = eng_stage_out;
    prev_x     = eng_x_out;
    if (valid_out) vo_count++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  function automatic logic [31:0] abs_sat(input logic [31:0] v);
    if (v == 32'h8000_0000) return 32'h7FFF_FFFF;
    if (v[31]) return 32'd0 - v;
    return v;
  endfunction

  function automatic logic [31:0] exp_env(input int ch, input logic [31:0] m, input bit fmin);
    logic [31:0] my;
    my = (fmin && ch == 0) ? 32'h8000_0000 : m + 32'(ch * 256);
    return abs_sat(my) + 32'(ch * 256) + 32'd1;
  endfunction

  function automatic logic [31:0] exp_car(input int ch, input logic [31:0] c);
    return c + 32'(ch * 256) + 32'd2;
  endfunction

  task automatic check_all(input string tag, input logic [31:0] m, input logic [31:0] c, input bit fmin);
    for (int i = 0; i < N_CH; i++) begin
      check_val($sformatf("%s_env%0d", tag, i), envelope_out[32*i +: 32], exp_env(i, m, fmin));
      check_val($sformatf("%s_car%0d", tag, i), carrier_out[32*i +: 32], exp_car(i, c));
    end
  endtask

  task automatic send(input logic [31:0] m, input logic [31:0] c);
    @(negedge clk_in);
    valid_in     = 1'b1;
    modulator_in = m[23:0];
    carrier_in   = c[15:0];
    @(posedge clk_in);
    #1 valid_in = 1'b0;
  endtask

  // Counts falling edges until valid_out; 0 means the budget expired.
  task automatic wait_done(input int limit, output int lat);
    lat = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk_in);
      if (valid_out) begin
        lat = i;
        break;
      end
    end
  endtask

  int lat, changes, v0, sv0;
  logic [32*N_CH-1:0] snap_env, snap_car;

  initial begin
    // Reset state
    repeat (3) @(negedge clk_in);
    check_val("rst_busy", {31'd0, busy_out}, 32'd0);
    check_val("rst_valid", {31'd0, valid_out}, 32'd0);
    check_val("rst_ovr", {31'd0, overrun_out}, 32'd0);
    check_val("rst_req", {31'd0, eng_req_out}, 32'd0);
    check_val("rst_env_any", {31'd0, |envelope_out}, 32'd0);
    check_val("rst_car_any", {31'd0, |carrier_out}, 32'd0);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);

    // Single sample, zero-stall engine: latency 49 and hand-computed channel 3
    send(32'd100, -32'sd5);
    wait_done(200, lat);
    check_val("lat_basic", 32'(lat), 32'd49);
    check_val("basic_busy_at_valid", {31'd0, busy_out}, 32'd0);
    check_val("basic_env3", envelope_out[32*3 +: 32], 32'd1637);
    check_val("basic_car3", carrier_out[32*3 +: 32], 32'd765);
    check_all("basic", 32'd100, -32'sd5, 1'b0);
    @(negedge clk_in);
    check_val("basic_valid_pulse", {31'd0, valid_out}, 32'd0);

    // Negative modulator: ENV input of channel 0 is the magnitude
    send(-32'sd1000, 32'd7);
    wait_done(200, lat);
    check_val("neg_done", 32'(lat), 32'd49);
    check_val("neg_env_x0", env_x0, 32'd1000);
    check_all("neg", -32'sd1000, 32'd7, 1'b0);

    // Most negative modulator with a forced -2^31 MOD result on channel 0
    force_min = 1'b1;
    send(-32'sd8388608, -32'sd32768);
    wait_done(200, lat);
    force_min = 1'b0;
    check_val("sat_done", 32'(lat), 32'd49);
    check_val("sat_env_x0", env_x0, 32'h7FFF_FFFF);
    check_all("sat", -32'sd8388608, -32'sd32768, 1'b1);

    // Stalling engine: request fields hold, arrays hold until commit, results equal zero-stall run
    snap_env   = envelope_out;
    snap_car   = carrier_out;
    sv0        = stall_viol;
    changes    = 0;
    ready_rand = 1'b1;
    delay_rand = 1'b1;
    send(32'd100, -32'sd5);
    lat = 0;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk_in);
      if (valid_out) begin
        lat = i;
        break;
      end
      if (envelope_out !== snap_env || carrier_out !== snap_car) changes++;
    end
    ready_rand = 1'b0;
    delay_rand = 1'b0;
    check_val("stall_done", {31'd0, lat != 0}, 32'd1);
    check_val("stall_arrays_held", 32'(changes), 32'd0);
    check_val("stall_fields_held", 32'(stall_viol - sv0), 32'd0);
    check_all("stall", 32'd100, -32'sd5, 1'b0);
    repeat (8) @(negedge clk_in);

    // Samples while busy: dropped, or one buffered when the skid is present
    v0 = vo_count;
    send(32'd100, -32'sd5);
    repeat (9) @(negedge clk_in);
    send(32'd200, 32'd40);
    check_val("ovr_after_b", {31'd0, overrun_out}, {31'd0, !SKID});
    repeat (9) @(negedge clk_in);
    send(32'd7, 32'd9);
    check_val("ovr_after_c", {31'd0, overrun_out}, 32'd1);
    repeat (150) @(negedge clk_in);
    check_val("ovr_pulses", 32'(vo_count - v0), SKID ? 32'd2 : 32'd1);
    check_val("ovr_final_car0", carrier_out[31:0], SKID ? 32'd42 : -32'sd3);

    // Reset in the middle of a sequence, then stray results
    send(32'd100, -32'sd5);
    repeat (20) @(negedge clk_in);
    v0 = vo_count;
    rst_in = 1'b0;
    #1;
    check_val("mid_rst_busy", {31'd0, busy_out}, 32'd0);
    check_val("mid_rst_req", {31'd0, eng_req_out}, 32'd0);
    check_val("mid_rst_ovr", {31'd0, overrun_out}, 32'd0);
    check_val("mid_rst_env_any", {31'd0, |envelope_out}, 32'd0);
    check_val("mid_rst_car_any", {31'd0, |carrier_out}, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    stray_cnt++;
    repeat (6) @(negedge clk_in);
    check_val("stray_busy", {31'd0, busy_out}, 32'd0);
    check_val("stray_pulses", 32'(vo_count - v0), 32'd0);
    check_val("stray_env_any", {31'd0, |envelope_out}, 32'd0);
    send(32'd100, -32'sd5);
    wait_done(200, lat);
    check_val("post_rst_lat", 32'(lat), 32'd49);
    check_all("post_rst", 32'd100, -32'sd5, 1'b0);

    // New sample presented in the commit cycle is accepted back-to-back
    valid_in     = 1'b1;
    modulator_in = 24'd300;
    carrier_in   = 16'd11;
    @(posedge clk_in);
    #1 valid_in = 1'b0;
    @(negedge clk_in);
    check_val("b2b_busy", {31'd0, busy_out}, 32'd1);
    check_val("b2b_ovr", {31'd0, overrun_out}, 32'd0);
    wait_done(200, lat);
    check_val("b2b_lat", 32'(lat), 32'd48);
    check_all("b2b", 32'd300, 32'd11, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
